// File: rtl/pdp8l_ptp_sequencer.sv
// Paper-tape-punch sequencer: captures each punch character into a 16-deep FIFO for the ARM.
// Latency: capture to punch_done is cycles+2 CSTEP clocks (capture clock included); armrdata is combinational.
// Backpressure: a full FIFO parks the punch in STALL until the ARM pops, so characters are never dropped.
module pdp8l_ptp_sequencer #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [23:0] DEF_CYCLES = 24'd2000000
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        CSTEP,
  input  logic        punch_busy,
  input  logic [7:0]  punch_char,
  output logic        punch_done,
  input  logic        armwrite,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  input  logic [1:0]  armraddr,
  output logic [31:0] armrdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STALL   = 3'd1,
    S_PUNCH   = 3'd2,
    S_DONE    = 3'd3,
    S_WAITCLR = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic                  enable;
  logic [23:0]           cycles;
  logic [23:0]           counter;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;

  logic       empty, full;
  logic       cfg_write, flush, pop, en_now;
  logic       push, push_eff, load, dec, clr;
  logic [7:0] head;
  logic       unused_bits;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign head  = empty ? 8'h00 : mem[rptr];

  assign cfg_write = armwrite && (armwaddr == 2'd1);
  assign flush     = cfg_write && armwdata[30];
  assign pop       = armwrite && (armwaddr == 2'd3) && !empty;
  // A same-clock ARM write to the enable bit wins over the stored value.
  assign en_now    = cfg_write ? armwdata[31] : enable;
  // A pop in the same clock frees the slot; a flush discards the push.
  assign push_eff  = push && (!full || pop) && !flush;

  assign unused_bits = ^armwdata[29:24];

  // State register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    load    = 1'b0;
    dec     = 1'b0;
    clr     = 1'b0;
    if (!en_now && state_q != S_IDLE) begin
      state_d = S_IDLE;
      clr     = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (CSTEP && en_now && punch_busy) begin
            if (!full) begin
              push    = 1'b1;
              load    = 1'b1;
              state_d = S_PUNCH;
            end else begin
              state_d = S_STALL;
            end
          end
        end
        S_STALL: begin
          if (CSTEP) begin
            if (!punch_busy) begin
              state_d = S_IDLE;
            end else if (!full) begin
              push    = 1'b1;
              load    = 1'b1;
              state_d = S_PUNCH;
            end
          end
        end
        S_PUNCH: begin
          if (CSTEP) begin
            if (counter == 24'd0) state_d = S_DONE;
            else                  dec     = 1'b1;
          end
        end
        S_DONE:    state_d = S_WAITCLR;
        S_WAITCLR: if (CSTEP && !punch_busy) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Punch-timing countdown and the registered done pulse.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      counter    <= 24'd0;
      punch_done <= 1'b0;
    end else begin
      if (clr)       counter <= 24'd0;
      else if (load) counter <= cycles;
      else if (dec)  counter <= counter - 24'd1;
      punch_done <= (state_d == S_DONE);
    end
  end

  // Configuration register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      enable <= 1'b0;
      cycles <= DEF_CYCLES;
    end else if (cfg_write) begin
      enable <= armwdata[31];
      cycles <= armwdata[23:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_eff) wptr <= wptr + 1'b1;
      if (pop)      rptr <= rptr + 1'b1;
      count <= count + (DEPTH_LOG2+1)'(push_eff) - (DEPTH_LOG2+1)'(pop);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge CLOCK) begin
    if (push_eff) mem[wptr] <= punch_char;
  end

  // ARM read mux.
  always_comb begin
    armrdata = 32'h0;
    case (armraddr)
      2'd0: armrdata = 32'h5053_1001;
      2'd1: armrdata = {enable, 7'b0, cycles};
      2'd2: armrdata = {empty, full, overflow, 5'(count), 4'({1'b0, state_q}), 12'b0, head};
      default: armrdata = 32'h0;
    endcase
  end

endmodule

// File: doc/pdp8l_ptp_sequencer.md
Name: pdp8l_ptp_sequencer

Overview:
- Sequences the paper-tape-punch datapath: each time the punch interface raises busy with a character, this block captures that character into a FIFO drained by the ARM.
- It emulates punch mechanism timing with a programmable countdown, then returns a one-cycle done pulse that sets the punch flag and clears busy.
- Sits between the punch IOP decoder and the ARM register bus, replacing software polling of the busy bit.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries of 8 bits).
- DEF_CYCLES, 24'd2000000, reset value of punch period in CSTEP-enabled clocks (20 ms at 100 MHz, 50 cps).

Ports:
- CLOCK  input  1  system clock; all logic on posedge.
- RESET_N  input  1  asynchronous, active-low reset.
- CSTEP  input  1  clock-step enable; state machine and countdown advance only when high.
- punch_busy  input  1  level from the punch interface: character pending.
- punch_char  input  8  character to punch, valid while punch_busy is high.
- punch_done  output  1  one-cycle pulse: punch complete (sets flag, clears busy).
- armwrite  input  1  ARM register write strobe.
- armwaddr  input  2  ARM write register index.
- armwdata  input  32  ARM write data.
- armraddr  input  2  ARM read register index.
- armrdata  output  32  ARM read data (combinational).

Behaviour:
- ARM register map:
  - [0] read: 32'h50531001 ('PS', [15:12]=1 for 4 regs, version 001).
  - [1] R/W: [31]=enable, [23:0]=cycles. Write with [30]=1 flushes the FIFO (self-clearing, reads 0) and clears overflow.
  - [2] RO: [31]=empty, [30]=full, [29]=overflow (sticky), [28:24]=count, [23:20]=state code, [7:0]=head char (0 when empty).
  - [3] write (any data) pops the head entry. A pop when empty is ignored. Reads return 0.
- Reset (RESET_N low, asynchronous):
  - enable=0, cycles=DEF_CYCLES, FIFO empty, overflow=0, state=IDLE, counter=0, punch_done=0.
- ARM writes take priority over CSTEP logic in the same clock. Pop and push in the same clock are both performed and count is unchanged. A flush in the same clock as a push leaves the FIFO empty, with overflow=0.
- States (code in [23:20]):
  - IDLE(0): if CSTEP & enable & punch_busy: if FIFO not full, push punch_char, load counter=cycles, go PUNCH. If FIFO full, go STALL.
  - STALL(1): on CSTEP, when FIFO not full, push punch_char, load counter, go PUNCH.
  - PUNCH(2): on CSTEP, if counter==0 go DONE, else decrement. cycles=0 therefore gives one CSTEP in PUNCH.
  - DONE(3): punch_done=1 for exactly this one clock; next clock go WAITCLR.
  - WAITCLR(4): on CSTEP, when punch_busy==0 go IDLE. A new character is never captured before busy drops.
- Latency: capture to punch_done = cycles+2 CSTEP clocks when the FIFO is not full.
- Overflow: set only if a push would exceed depth. The STALL state prevents this in normal operation, so overflow indicates an internal fault.
- Enable cleared mid-operation (any non-IDLE state):
  - Next clock goes to IDLE, counter=0, no punch_done.
  - A character already captured stays in the FIFO.
- Changing cycles during PUNCH does not affect the running countdown.
- punch_done is registered, never combinational.
- Pointer arithmetic wraps modulo 2^DEPTH_LOG2. count is DEPTH_LOG2+1 bits wide.

Test Plan:
- Reset, read reg0 -> 32'h50531001; reg2 -> empty=1, count=0, state=0; reg1[23:0] = 24'd2000000.
- enable=1, cycles=3, CSTEP=1, punch_busy with char 8'h41 -> FIFO count=1, head=8'h41, punch_done pulses exactly once, 5 clocks after capture. Busy held -> stays WAITCLR; drop busy -> IDLE. Pop -> empty.
- 16 punches without popping, then a 17th busy -> state=1 (STALL), no punch_done, overflow=0. One pop -> character captured, PUNCH entered, count=16.
- CSTEP toggled 1-in-4 with cycles=2 -> punch_done occurs after exactly 4 CSTEP-high clocks; counter frozen while CSTEP=0.
- Clear enable during PUNCH -> IDLE next clock, no punch_done, captured char retained. Assert RESET_N low mid-PUNCH -> all state cleared immediately, without waiting for a clock edge.
- Same-clock push and pop with count=5 -> count stays 5. Flush simultaneous with push -> empty, overflow=0. Pop when empty -> no change.
